alu_cmd_pipe: RTL

//  Registered, handshaked command stage in front of the mode-selected 32-bit ALU datapath.

---
 rtl/alu_cmd_pkg.sv | 16 +
 rtl/alu_cmd_core.sv | 33 +++
 rtl/alu_cmd_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/alu_cmd_pkg.sv
// Shared types and constants for the ALU command pipeline.
package alu_cmd_pkg;

  // Operation select carried with every command and echoed with its result.
  typedef enum logic [1:0] {
    OP_ADD_X2   = 2'b00,
    OP_SUB_DIV3 = 2'b01,
    OP_SHIFT_OR = 2'b10,
    OP_NEG_XOR  = 2'b11
  } op_mode_e;

  localparam int DIV_CONST = 3;
  localparam int SHL_AMT   = 4;
  localparam int SHR_AMT   = 2;

endpackage

// File: rtl/alu_cmd_core.sv
// Pure combinational ALU: one result per {mode, a, b}, all arithmetic
// unsigned and modulo 2^W.
module alu_cmd_core
  import alu_cmd_pkg::*;
#(
  parameter int W = 32
) (
  input  op_mode_e       mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   result
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;

  // Wrap happens here, before the shift/divide, so both ops see the mod-2^W value.
  assign sum  = a + b;
  assign diff = a - b;

  // Mode-selected result; the divide is by a constant so it stays combinational.
  always_comb begin
    result = '0;
    case (mode)
      OP_ADD_X2:   result = sum << 1;
      OP_SUB_DIV3: result = diff / W'(DIV_CONST);
      OP_SHIFT_OR: result = (a << SHL_AMT) | (b >> SHR_AMT);
      OP_NEG_XOR:  result = ~(a ^ b) + W'(1);
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_pipe.sv
// Two-stage registered command pipeline around alu_cmd_core, with an
// output-handshake counter and an XOR checksum of delivered results.
module alu_cmd_pipe
  import alu_cmd_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] op_count,
  output logic [W-1:0]     checksum
);

  // Handshake rule on both sides: a transfer happens on a rising edge where
  // valid & ready are both high; a producer holding valid keeps its data
  // stable until that edge, and ready never looks at the same-side valid.

  // S1: registered command
  logic         s1_valid;
  op_mode_e     s1_mode;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;

  // S2: registered result (drives the outputs directly)
  logic         s2_valid;
  logic [1:0]   s2_mode;
  logic [W-1:0] s2_result;

  logic [W-1:0] core_result;
  logic         s2_adv;
  logic         s1_adv;
  logic         accept;
  logic         out_fire;

  alu_cmd_core #(.W(W)) u_core (
    .mode   (s1_mode),
    .a      (s1_a),
    .b      (s1_b),
    .result (core_result)
  );

  // A stage may load when it is empty or its contents move on this edge.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !flush && rst_n;
  assign accept   = in_valid && in_ready;
  assign out_fire = s2_valid && out_ready;

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_mode   = s2_mode;

  // Stage registers: flush drops both valids; data only moves on advance, so a
  // stalled or emptied stage keeps its last contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_mode   <= OP_ADD_X2;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      s2_mode   <= 2'b00;
      s2_result <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_result <= core_result;
          s2_mode   <= s1_mode;
        end
      end
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_mode <= op_mode_e'(in_mode);
          s1_a    <= in_a;
          s1_b    <= in_b;
        end
      end
    end
  end

  // Delivery statistics: counted on every output handshake, flush or not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
      checksum <= '0;
    end else if (out_fire) begin
      if (op_count != {CNT_W{1'b1}}) begin
        op_count <= op_count + CNT_W'(1);
      end
      checksum <= checksum ^ s2_result;
    end
  end

endmodule
